// File: rtl/round_pkg.sv
// Shared types and constants for the round tracker: FSM state encoding and time width.
package round_pkg;

    localparam int TIME_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        OVER    = 2'd2,
        PAUSED  = 2'd3
    } round_state_t;

endpackage

// File: rtl/second_tick_gen.sv
// Prescaler counting 0..CLK_HZ-1; emits a one-cycle tick on the cycle it wraps.
// clear has priority over hold; tick is suppressed while clearing or holding.
module second_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int              CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (!hold) begin
            if (w_wrap) r_cnt <= '0;
            else        r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = !clear && !hold && w_wrap;

endmodule

// File: rtl/round_tracker.sv
// Round countdown plus sticky order flags; freezes both on timeout or all orders done.
// Optional pause support is built when ROUND_PAUSE_EN is defined (adds pause port, PAUSED state).
module round_tracker
    import round_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int ROUND_SECONDS = 180,
    parameter int NUM_ORDERS    = 3
) (
    input  logic                  basys_clk,
    input  logic                  reset,
    input  logic                  start,
`ifdef ROUND_PAUSE_EN
    input  logic                  pause,
`endif
    input  logic [NUM_ORDERS-1:0] order_complete,
    output logic [NUM_ORDERS-1:0] orders_done,
    output logic [TIME_W-1:0]     time_left,
    output logic                  running,
    output logic                  round_over
);

    localparam logic [TIME_W-1:0] TIME_LOAD = TIME_W'(ROUND_SECONDS);

    round_state_t          r_state;
    logic [TIME_W-1:0]     r_time_left;
    logic [NUM_ORDERS-1:0] r_orders_done;

    logic                  w_tick;
    logic                  w_pause;
    logic [NUM_ORDERS-1:0] w_done_nxt;
    logic                  w_all_done;

`ifdef ROUND_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_done_nxt = r_orders_done | order_complete;
    assign w_all_done = &w_done_nxt;

    second_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk   (basys_clk),
        .rst   (reset),
        .clear (start),
        .hold  (r_state != RUNNING),
        .tick  (w_tick)
    );

    always_ff @(posedge basys_clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_time_left   <= TIME_LOAD;
            r_orders_done <= '0;
        end else if (start) begin
            r_state       <= RUNNING;
            r_time_left   <= TIME_LOAD;
            r_orders_done <= '0;
        end else begin
            case (r_state)
                RUNNING: begin
                    r_orders_done <= w_done_nxt;
                    // Completing every order wins over a coincident tick, so time_left is not decremented.
                    if (w_all_done) begin
                        r_state <= OVER;
                    end else begin
                        if (w_tick && (r_time_left != '0))
                            r_time_left <= r_time_left - TIME_W'(1);
                        if (w_tick && (r_time_left == TIME_W'(1)))
                            r_state <= OVER;
                        else if (w_pause)
                            r_state <= PAUSED;
                    end
                end
                PAUSED: begin
                    if (w_pause) r_state <= RUNNING;
                end
                default: begin
                end
            endcase
        end
    end

    assign time_left   = r_time_left;
    assign orders_done = r_orders_done;
    assign running     = (r_state == RUNNING) || (r_state == PAUSED);
    assign round_over  = (r_state == OVER);

endmodule

// File: tb/tb_round_tracker.sv
// Directed table-driven bench for round_tracker with CLK_HZ=4, ROUND_SECONDS=5, NUM_ORDERS=3.
module tb_round_tracker;

    typedef struct {
        string       nm;
        logic        st;
        logic [2:0]  oc;
        int          n;
        logic [15:0] tl;
        logic [2:0]  od;
        logic        run;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pause;
    logic [2:0]  order_complete;
    logic [2:0]  orders_done;
    logic [15:0] time_left;
    logic        running;
    logic        round_over;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    round_tracker #(
        .CLK_HZ        (4),
        .ROUND_SECONDS (5),
        .NUM_ORDERS    (3)
    ) dut (
        .basys_clk      (clk),
        .reset          (reset),
        .start          (start),
`ifdef ROUND_PAUSE_EN
        .pause          (pause),
`endif
        .order_complete (order_complete),
        .orders_done    (orders_done),
        .time_left      (time_left),
        .running        (running),
        .round_over     (round_over)
    );

    function automatic vec_t mk(string nm, logic st, logic [2:0] oc, int n,
                                logic [15:0] tl, logic [2:0] od, logic run, logic ov);
        vec_t v;
        v.nm = nm; v.st = st; v.oc = oc; v.n = n;
        v.tl = tl; v.od = od; v.run = run; v.ov = ov;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] tl, input logic [2:0] od,
                       input logic run, input logic ov);
        checks++;
        if (time_left !== tl) begin
            errors++;
            $display("FAIL %s time_left got %0d want %0d", nm, time_left, tl);
        end
        checks++;
        if (orders_done !== od) begin
            errors++;
            $display("FAIL %s orders_done got %b want %b", nm, orders_done, od);
        end
        checks++;
        if (running !== run) begin
            errors++;
            $display("FAIL %s running got %b want %b", nm, running, run);
        end
        checks++;
        if (round_over !== ov) begin
            errors++;
            $display("FAIL %s round_over got %b want %b", nm, round_over, ov);
        end
    endtask

    // Inputs are driven for the first edge only; the check follows the n-th edge.
    task automatic run_vec(input vec_t v);
        start          = v.st;
        order_complete = v.oc;
        @(posedge clk); #1;
        start          = 1'b0;
        order_complete = 3'b000;
        for (int k = 1; k < v.n; k++) begin
            @(posedge clk); #1;
        end
        chk(v.nm, v.tl, v.od, v.run, v.ov);
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        pause          = 1'b0;
        order_complete = 3'b000;

        // timeout path
        tbl.push_back(mk("a_start",   1, 3'b000,  1, 5, 3'b000, 1, 0));
        tbl.push_back(mk("a_e3",      0, 3'b000,  3, 5, 3'b000, 1, 0));
        tbl.push_back(mk("a_e4",      0, 3'b000,  1, 4, 3'b000, 1, 0));
        tbl.push_back(mk("a_e8",      0, 3'b000,  4, 3, 3'b000, 1, 0));
        tbl.push_back(mk("a_e16",     0, 3'b000,  8, 1, 3'b000, 1, 0));
        tbl.push_back(mk("a_e19",     0, 3'b000,  3, 1, 3'b000, 1, 0));
        tbl.push_back(mk("a_timeout", 0, 3'b000,  1, 0, 3'b000, 0, 1));
        tbl.push_back(mk("a_hold",    0, 3'b101, 10, 0, 3'b000, 0, 1));
        // all orders done before timeout
        tbl.push_back(mk("b_start",   1, 3'b000,  1, 5, 3'b000, 1, 0));
        tbl.push_back(mk("b_e2",      0, 3'b000,  2, 5, 3'b000, 1, 0));
        tbl.push_back(mk("b_o0",      0, 3'b001,  1, 5, 3'b001, 1, 0));
        tbl.push_back(mk("b_e5",      0, 3'b000,  2, 4, 3'b001, 1, 0));
        tbl.push_back(mk("b_o2",      0, 3'b100,  1, 4, 3'b101, 1, 0));
        tbl.push_back(mk("b_e8",      0, 3'b000,  2, 3, 3'b101, 1, 0));
        tbl.push_back(mk("b_o1",      0, 3'b010,  1, 3, 3'b111, 0, 1));
        tbl.push_back(mk("b_hold",    0, 3'b000,  8, 3, 3'b111, 0, 1));
        // start beats order, tick with non-final order, final tick with last order
        tbl.push_back(mk("c_start_oc",1, 3'b111,  1, 5, 3'b000, 1, 0));
        tbl.push_back(mk("c_o1",      0, 3'b010,  1, 5, 3'b010, 1, 0));
        tbl.push_back(mk("c_e3",      0, 3'b000,  2, 5, 3'b010, 1, 0));
        tbl.push_back(mk("c_tick_o0", 0, 3'b001,  1, 4, 3'b011, 1, 0));
        tbl.push_back(mk("c_e16",     0, 3'b000, 12, 1, 3'b011, 1, 0));
        tbl.push_back(mk("c_e19",     0, 3'b000,  3, 1, 3'b011, 1, 0));
        tbl.push_back(mk("c_final",   0, 3'b100,  1, 1, 3'b111, 0, 1));
        tbl.push_back(mk("c_hold",    0, 3'b000,  5, 1, 3'b111, 0, 1));
        // restart while running
        tbl.push_back(mk("d_start",   1, 3'b000,  1, 5, 3'b000, 1, 0));
        tbl.push_back(mk("d_o2",      0, 3'b100,  1, 5, 3'b100, 1, 0));
        tbl.push_back(mk("d_e5",      0, 3'b000,  4, 4, 3'b100, 1, 0));
        tbl.push_back(mk("d_restart", 1, 3'b000,  1, 5, 3'b000, 1, 0));
        tbl.push_back(mk("d_e3",      0, 3'b000,  3, 5, 3'b000, 1, 0));
        tbl.push_back(mk("d_e4",      0, 3'b000,  1, 4, 3'b000, 1, 0));

        @(posedge clk); #1;
        chk("reset", 5, 3'b000, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            order_complete = (i % 3 == 0) ? 3'b111 : 3'b000;
            @(posedge clk); #1;
            chk("idle", 5, 3'b000, 0, 0);
        end
        order_complete = 3'b000;

        foreach (tbl[i]) run_vec(tbl[i]);

        // asynchronous reset mid-round at time_left=3
        run_vec(mk("r_start", 1, 3'b000, 1, 5, 3'b000, 1, 0));
        run_vec(mk("r_o0",    0, 3'b001, 1, 5, 3'b001, 1, 0));
        run_vec(mk("r_e9",    0, 3'b000, 8, 3, 3'b001, 1, 0));
        reset = 1'b1;
        #1;
        chk("r_async", 5, 3'b000, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_vec(mk("r_idle",  0, 3'b010, 3, 5, 3'b000, 0, 0));

        // start from OVER after a timeout
        run_vec(mk("s_start", 1, 3'b000, 1, 5, 3'b000, 1, 0));
        run_vec(mk("s_tmo",   0, 3'b000, 20, 0, 3'b000, 0, 1));
        run_vec(mk("s_again", 1, 3'b000, 1, 5, 3'b000, 1, 0));
        run_vec(mk("s_e3",    0, 3'b000, 3, 5, 3'b000, 1, 0));
        run_vec(mk("s_e4",    0, 3'b000, 1, 4, 3'b000, 1, 0));

`ifdef ROUND_PAUSE_EN
        run_vec(mk("p_start", 1, 3'b000, 1, 5, 3'b000, 1, 0));
        run_vec(mk("p_e6",    0, 3'b000, 6, 4, 3'b000, 1, 0));
        pause = 1'b1;
        @(posedge clk); #1;
        pause = 1'b0;
        chk("p_enter", 4, 3'b000, 1, 0);
        run_vec(mk("p_held",  0, 3'b001, 12, 4, 3'b000, 1, 0));
        pause = 1'b1;
        @(posedge clk); #1;
        pause = 1'b0;
        chk("p_resume", 4, 3'b000, 1, 0);
        @(posedge clk); #1;
        chk("p_tick", 3, 3'b000, 1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
